// File: rtl/demux_lane_array.sv
// demux_lane_array: NUM_IN independent 1:FANOUT demux lanes.
// Each lane spreads its valid words across FANOUT registered outputs, either
// round-robin over the enabled outputs or addressed by a per-lane select
// field. Undeliverable words are dropped and flagged with a one-cycle pulse.
module demux_lane_array #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 2,
  parameter int FANOUT     = 2,
  parameter int SEL_W      = $clog2(FANOUT)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_IN*DATA_WIDTH-1:0]        dataIn,
  input  logic [NUM_IN-1:0]                   validIn,
  input  logic [NUM_IN*SEL_W-1:0]             selIn,
  input  logic                               mode,
  input  logic [NUM_IN*FANOUT-1:0]            outEnable,
  input  logic                               restart,
  output logic [NUM_IN*FANOUT*DATA_WIDTH-1:0] dataOut_cond,
  output logic [NUM_IN*FANOUT-1:0]            validOut_cond,
  output logic [NUM_IN-1:0]                   dropOut
);

  // One extra bit so pointer arithmetic and the FANOUT bound never alias,
  // which matters when FANOUT is a power of two.
  localparam int PW   = SEL_W + 1;
  localparam int NOUT = NUM_IN * FANOUT;

  logic [NUM_IN*SEL_W-1:0] ptr_r;
  logic [NUM_IN*SEL_W-1:0] ptrNext_s;
  logic [NOUT-1:0]         deliver_s;
  logic [NUM_IN-1:0]       drop_s;

  // Search upward from start (with wrap) for the first enabled output.
  // Returns {found, index}.
  function automatic logic [SEL_W:0] rrSearch(
    input logic [FANOUT-1:0] en,
    input logic [SEL_W-1:0]  start
  );
    logic             found;
    logic [SEL_W-1:0] tgt;
    logic [PW-1:0]    cand;
    found = 1'b0;
    tgt   = '0;
    for (int k = 0; k < FANOUT; k++) begin
      cand = {1'b0, start} + PW'(k);
      cand = (cand >= PW'(FANOUT)) ? (cand - PW'(FANOUT)) : cand;
      if (!found && en[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        tgt   = cand[SEL_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, tgt};
  endfunction

  // Pointer successor; FANOUT-1 wraps to 0 so the counter never leaves range.
  function automatic logic [SEL_W-1:0] wrapInc(input logic [SEL_W-1:0] cur);
    logic [PW-1:0] inc;
    inc = {1'b0, cur} + PW'(1);
    return (inc >= PW'(FANOUT)) ? '0 : inc[SEL_W-1:0];
  endfunction

  // Per-lane dispatch decision: which output (if any) receives the word,
  // whether it is dropped, and the pointer for the next cycle.
  always_comb begin
    logic [FANOUT-1:0] laneEn;
    logic [SEL_W-1:0]  basePtr;
    logic [SEL_W:0]    search;
    logic [SEL_W-1:0]  sel;
    deliver_s = '0;
    drop_s    = '0;
    ptrNext_s = ptr_r;
    laneEn    = '0;
    basePtr   = '0;
    search    = '0;
    sel       = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      laneEn  = outEnable[i*FANOUT +: FANOUT];
      // restart makes this edge dispatch as if every pointer were already 0
      basePtr = restart ? '0 : ptr_r[i*SEL_W +: SEL_W];
      search  = rrSearch(laneEn, basePtr);
      sel     = selIn[i*SEL_W +: SEL_W];
      ptrNext_s[i*SEL_W +: SEL_W] = basePtr;
      if (validIn[i]) begin
        if (!mode) begin
          if (search[SEL_W]) begin
            deliver_s[i*FANOUT + int'(search[SEL_W-1:0])] = 1'b1;
            ptrNext_s[i*SEL_W +: SEL_W] = wrapInc(search[SEL_W-1:0]);
          end else begin
            drop_s[i] = 1'b1;
          end
        end else begin
          // addressed mode never moves the pointer
          if (({1'b0, sel} < PW'(FANOUT)) && laneEn[sel]) begin
            deliver_s[i*FANOUT + int'(sel)] = 1'b1;
          end else begin
            drop_s[i] = 1'b1;
          end
        end
      end else begin
        drop_s[i] = 1'b0;
      end
    end
  end

  // Register pointers and outputs; data slices keep their last delivered word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r         <= '0;
      dataOut_cond  <= '0;
      validOut_cond <= '0;
      dropOut       <= '0;
    end else begin
      ptr_r         <= ptrNext_s;
      validOut_cond <= deliver_s;
      dropOut       <= drop_s;
      for (int k = 0; k < NOUT; k++) begin
        if (deliver_s[k]) begin
          dataOut_cond[k*DATA_WIDTH +: DATA_WIDTH] <=
            dataIn[(k/FANOUT)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_array.sv
// Self-checking bench for demux_lane_array (NUM_IN=2, FANOUT=3).
// A behavioural model built on integer modulo arithmetic predicts every cycle;
// directed scenarios also check hand-derived constants.
module tb_demux_lane_array;

  localparam int W  = 8;
  localparam int NI = 2;
  localparam int F  = 3;
  localparam int SW = $clog2(F);

  logic                clk = 1'b0;
  logic                reset;
  logic [NI*W-1:0]     dataIn;
  logic [NI-1:0]       validIn;
  logic [NI*SW-1:0]    selIn;
  logic                mode;
  logic [NI*F-1:0]     outEnable;
  logic                restart;
  logic [NI*F*W-1:0]   dataOut_cond;
  logic [NI*F-1:0]     validOut_cond;
  logic [NI-1:0]       dropOut;

  int compared = 0;
  int failed   = 0;

  // model state
  logic [W-1:0]  mData [NI*F];
  logic [NI*F-1:0] mValid;
  logic [NI-1:0] mDrop;
  int            mPtr [NI];

  demux_lane_array #(.DATA_WIDTH(W), .NUM_IN(NI), .FANOUT(F)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn),
    .selIn(selIn), .mode(mode), .outEnable(outEnable), .restart(restart),
    .dataOut_cond(dataOut_cond), .validOut_cond(validOut_cond), .dropOut(dropOut)
  );

  always #5 clk = ~clk;

  function automatic logic [NI*F*W-1:0] modelData();
    logic [NI*F*W-1:0] v;
    v = '0;
    for (int k = 0; k < NI*F; k++) v[k*W +: W] = mData[k];
    return v;
  endfunction

  // Predict the effect of the edge about to happen from the current inputs.
  task automatic modelStep();
    int base, tgt, s;
    if (reset === 1'b0) begin
      for (int k = 0; k < NI*F; k++) mData[k] = '0;
      mValid = '0;
      mDrop  = '0;
      for (int i = 0; i < NI; i++) mPtr[i] = 0;
    end else begin
      mValid = '0;
      mDrop  = '0;
      for (int i = 0; i < NI; i++) begin
        base = restart ? 0 : mPtr[i];
        mPtr[i] = base;
        if (validIn[i]) begin
          tgt = -1;
          if (mode == 1'b0) begin
            for (int t = 0; t < F; t++)
              if (tgt < 0 && outEnable[i*F + (base+t)%F]) tgt = (base+t)%F;
            if (tgt >= 0) mPtr[i] = (tgt+1) % F;
          end else begin
            s = int'(selIn[i*SW +: SW]);
            if (s < F) begin
              if (outEnable[i*F+s]) tgt = s;
            end
          end
          if (tgt >= 0) begin
            mData[i*F+tgt]  = dataIn[i*W +: W];
            mValid[i*F+tgt] = 1'b1;
          end else begin
            mDrop[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    reset = 1'b1; dataIn = '0; validIn = '0; selIn = '0;
    mode = 1'b0; outEnable = '1; restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; restart = 1'b0;
    for (int n = 0; n < 2; n++) begin
      dataIn = NI*W'($urandom); validIn = '1; selIn = '0; outEnable = '1;
      tick();
      compared++;
      if (dataOut_cond !== '0 || validOut_cond !== '0 || dropOut !== '0) begin
        failed++;
        $display("FAIL reset_state: got data=%h valid=%b drop=%b, want all zero",
                 dataOut_cond, validOut_cond, dropOut);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] words [4];
    int           idx [4];
    words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    idx   = '{0, 1, 2, 0};
    idleInputs();
    for (int n = 0; n < 4; n++) begin
      dataIn = {8'h5C, words[n]}; validIn = 2'b01;
      tick();
      compared++;
      if (validOut_cond !== (6'b000001 << idx[n]) || dataOut_cond[idx[n]*W +: W] !== words[n] ||
          dataOut_cond[NI*F*W-1:F*W] !== '0 || dropOut !== 2'b00) begin
        failed++;
        $display("FAIL round_robin word %0d: got valid=%b data=%h drop=%b, want valid=%b slot%0d=%h lane1 quiet",
                 n, validOut_cond, dataOut_cond, dropOut, 6'b000001 << idx[n], idx[n], words[n]);
      end
    end
    validIn = 2'b00;
    tick();
    compared++;
    if (validOut_cond !== '0 || dataOut_cond !== modelData()) begin
      failed++;
      $display("FAIL rr_pulse_end: got valid=%b data=%h, want valid=0 data=%h",
               validOut_cond, dataOut_cond, modelData());
    end
  endtask

  task automatic test_skip_disabled();
    int idx [4];
    idx = '{0, 2, 0, 2};
    idleInputs();
    restart = 1'b1;
    tick();
    restart = 1'b0; outEnable = 6'b111_101;
    for (int n = 0; n < 4; n++) begin
      dataIn = {8'h00, W'(n+1)}; validIn = 2'b01;
      tick();
      compared++;
      if (validOut_cond !== (6'b000001 << idx[n]) || dataOut_cond[idx[n]*W +: W] !== W'(n+1) ||
          dropOut !== 2'b00) begin
        failed++;
        $display("FAIL skip_disabled word %0d: got valid=%b data=%h drop=%b, want slot %0d",
                 n, validOut_cond, dataOut_cond, dropOut, idx[n]);
      end
    end
  endtask

  task automatic test_addressed();
    idleInputs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    dataIn = {8'h11, 8'h00}; validIn = 2'b10;   // lane1 ptr -> 1
    tick();
    mode = 1'b1; selIn = {2'd2, 2'd0}; dataIn = {8'h55, 8'h00}; validIn = 2'b10;
    tick();
    compared++;
    if (validOut_cond !== 6'b100000 || dataOut_cond[5*W +: W] !== 8'h55 || dropOut !== 2'b00) begin
      failed++;
      $display("FAIL addressed_deliver: got valid=%b data=%h drop=%b, want valid=100000 slot5=55",
               validOut_cond, dataOut_cond, dropOut);
    end
    selIn = {2'd3, 2'd0}; dataIn = {8'h66, 8'h00};
    tick();
    compared++;
    if (validOut_cond !== '0 || dropOut !== 2'b10 || dataOut_cond[5*W +: W] !== 8'h55) begin
      failed++;
      $display("FAIL addressed_out_of_range: got valid=%b drop=%b slot5=%h, want valid=0 drop=10 slot5=55",
               validOut_cond, dropOut, dataOut_cond[5*W +: W]);
    end
    selIn = {2'd1, 2'd0}; outEnable = 6'b101_111; dataIn = {8'h67, 8'h00};
    tick();
    compared++;
    if (validOut_cond !== '0 || dropOut !== 2'b10) begin
      failed++;
      $display("FAIL addressed_disabled: got valid=%b drop=%b, want valid=0 drop=10",
               validOut_cond, dropOut);
    end
    mode = 1'b0; outEnable = '1; dataIn = {8'h88, 8'h00};
    tick();
    compared++;
    if (validOut_cond !== 6'b010000 || dataOut_cond[4*W +: W] !== 8'h88) begin
      failed++;
      $display("FAIL addressed_ptr_held: got valid=%b data=%h, want valid=010000 slot4=88",
               validOut_cond, dataOut_cond);
    end
  endtask

  task automatic test_all_disabled();
    logic [F*W-1:0] snap;
    idleInputs();
    snap = dataOut_cond[F*W-1:0];
    outEnable = 6'b111_000;
    for (int n = 0; n < 3; n++) begin
      dataIn = {8'h00, W'($urandom)}; validIn = 2'b01;
      tick();
      compared++;
      if (dropOut !== 2'b01 || validOut_cond !== '0 || dataOut_cond[F*W-1:0] !== snap) begin
        failed++;
        $display("FAIL all_disabled cycle %0d: got drop=%b valid=%b lane0=%h, want drop=01 valid=0 lane0=%h",
                 n, dropOut, validOut_cond, dataOut_cond[F*W-1:0], snap);
      end
    end
  endtask

  task automatic test_restart();
    idleInputs();
    restart = 1'b1;
    tick();
    restart = 1'b0; dataIn = {8'h00, 8'h70}; validIn = 2'b01;   // ptr0 -> 1
    tick();
    restart = 1'b1; dataIn = {8'h00, 8'h77};
    tick();
    compared++;
    if (validOut_cond !== 6'b000001 || dataOut_cond[0 +: W] !== 8'h77) begin
      failed++;
      $display("FAIL restart_same_edge: got valid=%b data=%h, want valid=000001 slot0=77",
               validOut_cond, dataOut_cond);
    end
    restart = 1'b0; dataIn = {8'h00, 8'h78};
    tick();
    compared++;
    if (validOut_cond !== 6'b000010 || dataOut_cond[W +: W] !== 8'h78) begin
      failed++;
      $display("FAIL restart_next: got valid=%b data=%h, want valid=000010 slot1=78",
               validOut_cond, dataOut_cond);
    end
  endtask

  task automatic test_reset_midstream();
    idleInputs();
    dataIn = {8'h41, 8'h31}; validIn = 2'b11;
    tick();
    reset = 1'b0; dataIn = {8'h42, 8'h32};
    tick();
    compared++;
    if (dataOut_cond !== '0 || validOut_cond !== '0 || dropOut !== '0) begin
      failed++;
      $display("FAIL reset_midstream: got data=%h valid=%b drop=%b, want all zero",
               dataOut_cond, validOut_cond, dropOut);
    end
    reset = 1'b1; dataIn = {8'h00, 8'h33}; validIn = 2'b01;
    tick();
    compared++;
    if (validOut_cond !== 6'b000001 || dataOut_cond !== {{(NI*F-1)*W{1'b0}}, 8'h33}) begin
      failed++;
      $display("FAIL after_reset_first: got valid=%b data=%h, want valid=000001 data=...33",
               validOut_cond, dataOut_cond);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) != 0);
      restart   = ($urandom_range(0, 19) == 0);
      mode      = ($urandom_range(0, 2) == 0);
      outEnable = NI*F'($urandom);
      if ($urandom_range(0, 3) == 0) outEnable = '1;
      selIn     = NI*SW'($urandom);
      validIn   = NI'($urandom);
      dataIn    = NI*W'($urandom);
      tick();
      compared++;
      if (dataOut_cond !== modelData() || validOut_cond !== mValid || dropOut !== mDrop) begin
        failed++;
        $display("FAIL random cycle %0d: got data=%h valid=%b drop=%b, want data=%h valid=%b drop=%b",
                 n, dataOut_cond, validOut_cond, dropOut, modelData(), mValid, mDrop);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI*F; k++) mData[k] = '0;
    mValid = '0; mDrop = '0;
    for (int i = 0; i < NI; i++) mPtr[i] = 0;
    reset = 1'b0; dataIn = '0; validIn = '0; selIn = '0;
    mode = 1'b0; outEnable = '1; restart = 1'b0;
    test_reset();
    test_round_robin();
    test_skip_disabled();
    test_addressed();
    test_all_disabled();
    test_restart();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/demux_lane_array.md
# demux_lane_array

Parametrised successor of the two-lane 1:2 demux layer in the serial-to-parallel datapath. It takes NUM_IN independent input lanes and spreads each one's valid words across FANOUT registered outputs. Two dispatch modes are supported: round-robin, which skips disabled outputs, and addressed, which routes each word by a select field. Words that cannot be delivered are dropped and flagged. It sits between the lane deserialiser and the per-channel conditioning stage.

## Interface
- DATA_WIDTH, 8, bits per word.
- NUM_IN, 2, input lanes (≥1).
- FANOUT, 2, outputs per lane (≥2).
- SEL_W, $clog2(FANOUT), width of a per-lane select field.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clk.
- dataIn  input  NUM_IN*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- validIn  input  NUM_IN  word-valid per lane.
- selIn  input  NUM_IN*SEL_W  addressed-mode target per lane.
- mode  input  1  0 = round-robin, 1 = addressed; shared by all lanes.
- outEnable  input  NUM_IN*FANOUT  per-output enable; bit i*FANOUT+j is output j of lane i.
- restart  input  1  synchronous clear of all round-robin pointers.
- dataOut_cond  output  NUM_IN*FANOUT*DATA_WIDTH  output k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], with k = i*FANOUT+j.
- validOut_cond  output  NUM_IN*FANOUT  one-cycle valid per output.
- dropOut  output  NUM_IN  one-cycle pulse: the lane's word was discarded.

## Operation
- Reset (reset==0 at edge):
  - all dataOut_cond = 0, validOut_cond = 0, dropOut = 0;
  - all pointers ptr[i] = 0.
  - Reset overrides every other input, including mid-stream.
- Each lane i is independent. It has a pointer ptr[i] in 0..FANOUT-1, held in a counter of SEL_W bits.
- Round-robin (mode=0), on an edge with validIn[i]=1:
  - target = first index t, searching upward from ptr[i] with wrap, with outEnable[i*FANOUT+t]=1;
  - the word is written to output i*FANOUT+target and its valid is set;
  - ptr[i] = (target+1) mod FANOUT.
  - If no output of the lane is enabled: the word is dropped, dropOut[i]=1, and ptr[i] is unchanged.
- Addressed (mode=1), on validIn[i]=1:
  - target = selIn[i];
  - if target ≥ FANOUT or the target output is disabled: drop, dropOut[i]=1;
  - otherwise the word is delivered to that output.
  - ptr[i] is never modified in addressed mode.
- validIn[i]=0: no output of lane i asserts valid, and ptr[i] holds.
- Data retention: each dataOut_cond slice holds its last delivered word until overwritten. It is not cleared when its valid deasserts.
- validOut_cond and dropOut are single-cycle pulses. They are 0 on any cycle without a new event.
- At most one output per lane is valid per cycle.
- restart=1 (with reset=1):
  - all ptr[i] are treated as 0 for this edge's dispatch;
  - post-edge ptr[i] = 0, or target+1 if a round-robin word was dispatched on the same edge.
- Changes to mode, outEnable and selIn take effect on the same edge they are sampled. There is no pipelining of control.
- Pointer wrap: ptr = FANOUT-1 advances to 0. For non-power-of-2 FANOUT the counter must never hold values ≥ FANOUT.

## Timing
- Latency: 1 cycle. A word sampled at edge n appears on dataOut_cond/validOut_cond after edge n, valid for exactly one cycle.
- Full throughput: one word per lane per cycle, sustained, in both modes.
- dropOut[i] asserts in the same cycle the delivered valid would have asserted.
- First valid after reset release goes to output 0 of each lane, provided it is enabled.
- No backpressure. Outputs accept every cycle.

## Test plan
- Reset then round-robin:
  - stimulus: NUM_IN=2, FANOUT=2, all enabled; lane0 words 0xA1,0xA2,0xA3 on consecutive cycles;
  - required: out0=0xA1, out1=0xA2, out0=0xA3, each valid 1 cycle, 1-cycle latency;
  - required: lane1 outputs quiet, values 0.
- Skip disabled:
  - stimulus: FANOUT=4, lane0 outEnable=4'b1011, words 1..4;
  - required: delivered to outputs 0,1,3,0 in order; dropOut never asserts.
- Addressed mode:
  - stimulus: mode=1, FANOUT=3; lane1 selIn=2 with word 0x55, then selIn=3 with 0x66;
  - required: out(1*3+2)=0x55 valid; then dropOut[1]=1 and no valid;
  - required: ptr unchanged, verified by switching to mode=0 and observing the next word at the pre-switch pointer.
- All outputs disabled:
  - stimulus: lane0 outEnable=0, validIn=1 for 3 cycles;
  - required: dropOut[0]=1 three cycles; data outputs retain prior values.
- Restart plus valid on the same edge:
  - stimulus: ptr=1, restart=1 with word 0x77;
  - required: 0x77 lands on output 0; next word lands on output 1.
- Reset mid-stream:
  - stimulus: reset=0 on the edge that also carries validIn=1;
  - required: all outputs 0, no valid, no drop; next word goes to output 0.
